// File: rtl/alu_txn_monitor.sv
// Passive ALU command/response monitor: pairs each command with its result and queues it in a FWFT FIFO.
// Optional reference-model checking is compiled in when ALU_MON_CHECK_EN is defined.
module alu_txn_monitor #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 32
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [7:0]  A_s,
  input  logic [7:0]  B_s,
  input  logic [2:0]  op_s,
  input  logic        start,
  input  logic        done,
  input  logic [15:0] res_o,
  input  logic        rd_en_i,
  output logic        rd_valid_o,
  output logic [34:0] rd_data_o,
  output logic [6:0]  count_o,
  output logic        busy_o,
  output logic        overflow_o,
  output logic        timeout_o,
  output logic        stray_o,
  output logic        mismatch_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t          r_state;
  logic            r_start_q;
  logic [7:0]      r_timer;
  logic [7:0]      r_a;
  logic [7:0]      r_b;
  logic [2:0]      r_op;
  logic [34:0]     r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [6:0]      r_count;
  logic            r_busy;
  logic            r_ovf;
  logic            r_to;
  logic            r_stray;

  logic            w_capture;
  logic            w_timed_out;
  logic            w_done_ok;
  logic            w_full;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;
  logic [34:0]     w_record;

  assign w_capture   = start && !r_start_q && (op_s != 3'b000);
  // Timeout takes precedence over a done arriving on the same edge.
  assign w_timed_out = (r_state == S_WAIT) && (r_timer == 8'(TIMEOUT));
  assign w_done_ok   = (r_state == S_WAIT) && !w_timed_out && done;
  assign w_full      = (r_count == 7'(DEPTH));
  assign w_pop       = rd_en_i && (r_count != 7'd0);
  assign w_push      = w_done_ok && (!w_full || w_pop);
  assign w_drop      = w_done_ok && w_full && !w_pop;
  assign w_record    = {r_op, r_a, r_b, res_o};

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state   <= S_IDLE;
      r_start_q <= 1'b0;
      r_timer   <= 8'd0;
      r_busy    <= 1'b0;
      r_ovf     <= 1'b0;
      r_to      <= 1'b0;
      r_stray   <= 1'b0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= 7'd0;
    end else begin
      r_start_q <= start;
      case (r_state)
        S_IDLE: begin
          if (w_capture) begin
            r_state <= S_WAIT;
            r_timer <= 8'd0;
            r_busy  <= 1'b1;
          end else if (done) begin
            r_stray <= 1'b1;
          end
        end
        S_WAIT: begin
          if (w_timed_out) begin
            r_to    <= 1'b1;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (done) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_timer <= r_timer + 8'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase

      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 7'd1;
        2'b01:   r_count <= r_count - 7'd1;
        default: r_count <= r_count;
      endcase
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  // Command operands and FIFO storage carry no reset; validity is tracked by state and count.
  always_ff @(posedge clk_i) begin
    if ((r_state == S_IDLE) && w_capture) begin
      r_a  <= A_s;
      r_b  <= B_s;
      r_op <= op_s;
    end
    if (w_push) r_mem[r_wr_ptr] <= w_record;
  end

  assign rd_valid_o = (r_count != 7'd0);
  assign rd_data_o  = rd_valid_o ? r_mem[r_rd_ptr] : 35'd0;
  assign count_o    = r_count;
  assign busy_o     = r_busy;
  assign overflow_o = r_ovf;
  assign timeout_o  = r_to;
  assign stray_o    = r_stray;

`ifdef ALU_MON_CHECK_EN
  logic r_mm;
  logic w_checked;

  function automatic logic [15:0] ref_result(input logic [2:0] op, input logic [7:0] a,
                                             input logic [7:0] b);
    case (op)
      3'b001:  ref_result = {8'h00, a} + {8'h00, b};
      3'b010:  ref_result = {8'h00, a & b};
      3'b011:  ref_result = {8'h00, a ^ b};
      3'b100:  ref_result = 16'(a) * 16'(b);
      default: ref_result = 16'h0000;
    endcase
  endfunction

  assign w_checked = (r_op >= 3'd1) && (r_op <= 3'd4);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_mm <= 1'b0;
    end else if (w_done_ok && w_checked && (ref_result(r_op, r_a, r_b) != res_o)) begin
      r_mm <= 1'b1;
    end
  end

  assign mismatch_o = r_mm;
`else
  assign mismatch_o = 1'b0;
`endif

endmodule

// File: tb/tb_alu_txn_monitor.sv
// Scoreboard bench for alu_txn_monitor: directed ALU transactions, FIFO drain compared against an expected queue.
module tb_alu_txn_monitor;

`ifdef ALU_MON_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [7:0]  A_s;
  logic [7:0]  B_s;
  logic [2:0]  op_s;
  logic        start;
  logic        done;
  logic [15:0] res_o;
  logic        rd_en_i;
  logic        rd_valid_o;
  logic [34:0] rd_data_o;
  logic [6:0]  count_o;
  logic        busy_o;
  logic        overflow_o;
  logic        timeout_o;
  logic        stray_o;
  logic        mismatch_o;

  int          total = 0;
  int          bad   = 0;
  logic [34:0] exp_q[$];
  int          busy_n;

  alu_txn_monitor #(.DEPTH(8), .TIMEOUT(32)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .A_s(A_s), .B_s(B_s), .op_s(op_s),
    .start(start), .done(done), .res_o(res_o), .rd_en_i(rd_en_i),
    .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o), .count_o(count_o),
    .busy_o(busy_o), .overflow_o(overflow_o), .timeout_o(timeout_o),
    .stray_o(stray_o), .mismatch_o(mismatch_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted pop is checked against the oldest expected record.
  always @(negedge clk_i) begin
    logic [34:0] e;
    if (!reset_i && rd_en_i && rd_valid_o) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL fifo_pop: got %0h expected no entry", rd_data_o);
      end else begin
        e = exp_q.pop_front();
        chk("fifo_pop", rd_data_o, e);
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [15:0] alu_res(input logic [2:0] op, input logic [7:0] a,
                                          input logic [7:0] b);
    case (op)
      3'b001:  alu_res = 16'(a) + 16'(b);
      3'b010:  alu_res = {8'h00, a & b};
      3'b011:  alu_res = {8'h00, a ^ b};
      3'b100:  alu_res = 16'(a) * 16'(b);
      default: alu_res = 16'h0000;
    endcase
  endfunction

  task automatic do_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input int lat, input logic [15:0] res, input bit qpush,
                        input bit pop_at_done, output int busy_cycles);
    op_s  = op;
    A_s   = a;
    B_s   = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    busy_cycles = 0;
    if (busy_o) busy_cycles++;
    repeat (lat - 1) begin
      tick();
      if (busy_o) busy_cycles++;
    end
    done  = 1'b1;
    res_o = res;
    if (pop_at_done) rd_en_i = 1'b1;
    if (qpush) exp_q.push_back({op, a, b, res});
    tick();
    done    = 1'b0;
    rd_en_i = 1'b0;
    if (busy_o) busy_cycles++;
  endtask

  task automatic drain(input int n);
    rd_en_i = 1'b1;
    repeat (n) tick();
    rd_en_i = 1'b0;
  endtask

  initial begin
    reset_i = 1'b1;
    A_s = 8'h00; B_s = 8'h00; op_s = 3'b000;
    start = 1'b0; done = 1'b0; res_o = 16'h0000; rd_en_i = 1'b0;
    tick();
    tick();
    chk("reset_valid", rd_valid_o, 0);
    chk("reset_count", count_o, 0);
    chk("reset_busy", busy_o, 0);
    chk("reset_flags", {overflow_o, timeout_o, stray_o, mismatch_o}, 0);
    reset_i = 1'b0;
    tick();

    // add, minimum latency
    do_cmd(3'b001, 8'h12, 8'h34, 1, 16'h0046, 1'b1, 1'b0, busy_n);
    chk("add_valid", rd_valid_o, 1);
    chk("add_data", rd_data_o, {3'b001, 8'h12, 8'h34, 16'h0046});
    chk("add_count", count_o, 1);
    chk("add_mismatch", mismatch_o, 0);

    // mul, 3-cycle latency, then a wrong result
    do_cmd(3'b100, 8'hFF, 8'hFF, 3, 16'hFE01, 1'b1, 1'b0, busy_n);
    chk("mul_busy_cycles", busy_n, 3);
    chk("mul_count", count_o, 2);
    chk("mul_mismatch_ok", mismatch_o, 0);
    do_cmd(3'b100, 8'hFF, 8'hFF, 2, 16'hFE00, 1'b1, 1'b0, busy_n);
    chk("mul_mismatch_bad", mismatch_o, CHK);
    chk("mul_bad_pushed", count_o, 3);
    drain(3);
    chk("drain1_valid", rd_valid_o, 0);
    chk("drain1_count", count_o, 0);
    chk("drain1_data", rd_data_o, 0);

    // fill to DEPTH, pop+push while full, then overflow
    for (int i = 0; i < 8; i++) begin
      logic [2:0] op;
      logic [7:0] a;
      logic [7:0] b;
      op = 3'(i % 4 + 1);
      a  = 8'(8'h20 + i * 17);
      b  = 8'(8'h03 + i);
      do_cmd(op, a, b, i % 3 + 1, alu_res(op, a, b), 1'b1, 1'b0, busy_n);
    end
    chk("full_count", count_o, 8);
    chk("full_overflow", overflow_o, 0);
    do_cmd(3'b011, 8'hA5, 8'h5A, 1, 16'h00FF, 1'b1, 1'b1, busy_n);
    chk("pushpop_count", count_o, 8);
    chk("pushpop_overflow", overflow_o, 0);
    do_cmd(3'b010, 8'hF0, 8'h3C, 2, 16'h0030, 1'b0, 1'b0, busy_n);
    chk("ovf_count", count_o, 8);
    chk("ovf_flag", overflow_o, 1);
    drain(8);
    chk("drain2_valid", rd_valid_o, 0);
    chk("drain2_count", count_o, 0);
    chk("drain2_scoreboard", exp_q.size(), 0);

    // timeout then stray done
    op_s = 3'b011; A_s = 8'h0F; B_s = 8'hF0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (32) tick();
    chk("timeout_early", timeout_o, 0);
    chk("timeout_busy", busy_o, 1);
    tick();
    chk("timeout_flag", timeout_o, 1);
    chk("timeout_idle", busy_o, 0);
    chk("timeout_nopush", count_o, 0);
    repeat (6) tick();
    chk("stray_before", stray_o, 0);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("stray_flag", stray_o, 1);
    chk("stray_nopush", count_o, 0);

    // start held over two done cycles, then no_op pulses
    op_s = 3'b001; A_s = 8'h21; B_s = 8'h43;
    start = 1'b1;
    tick();
    done = 1'b1;
    res_o = 16'h0064;
    exp_q.push_back({3'b001, 8'h21, 8'h43, 16'h0064});
    tick();
    tick();
    done = 1'b0;
    start = 1'b0;
    tick();
    op_s = 3'b000;
    repeat (2) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
    end
    chk("held_count", count_o, 1);
    chk("noop_busy", busy_o, 0);

    // reset while a command is pending
    op_s = 3'b100; A_s = 8'h07; B_s = 8'h09;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("pend_busy", busy_o, 1);
    #2 reset_i = 1'b1;
    #1;
    chk("midrst_valid", rd_valid_o, 0);
    chk("midrst_count", count_o, 0);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_data", rd_data_o, 0);
    chk("midrst_flags", {overflow_o, timeout_o, stray_o, mismatch_o}, 0);
    exp_q.delete();
    tick();
    reset_i = 1'b0;
    tick();

    // post-reset transaction
    do_cmd(3'b011, 8'hC3, 8'h3C, 2, 16'h00FF, 1'b1, 1'b0, busy_n);
    chk("post_count", count_o, 1);
    drain(1);
    chk("post_scoreboard", exp_q.size(), 0);
    chk("post_valid", rd_valid_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
